node_router: RTL

Parametrised N-port router node; successor to the fixed four-interface node, which only buffered traffic. Each input port gets a FIFO. A single-flit destination field selects the output port. A per-output round-robin arbiter resolves contention, and each output port has a registered stage with full/valid backpressure. The block sits between the per-link converters and the node's neighbours/local endpoint, one instance per mesh node.

---
 rtl/node_router_pkg.sv | 51 +++++
 rtl/router_fifo.sv | 64 ++++++
 rtl/node_router.sv | 124 ++++++++++++
 3 files changed

// File: rtl/node_router_pkg.sv
// Shared types and helpers for the mesh router node: port indices, the
// destination-field extractor and the cyclic round-robin search.
package node_router_pkg;

    localparam int MAX_PORTS  = 8;
    localparam int PORT_W     = 3;
    localparam int FLIT_W     = 16;
    localparam int MAX_FLIT_W = 64;

    typedef logic [FLIT_W-1:0] flit_t;
    typedef logic [PORT_W-1:0] port_idx_t;

    typedef struct packed {
        logic      found;
        port_idx_t winner;
    } rr_pick_t;

    // Destination is the top dest_w bits of a flit zero-extended to MAX_FLIT_W.
    function automatic port_idx_t dest_of(input logic [MAX_FLIT_W-1:0] flit,
                                          input int data_width,
                                          input int dest_w);
        port_idx_t  d;
        logic [5:0] pos;
        d = '0;
        for (int b = 0; b < PORT_W; b++) begin
            if (b < dest_w) begin
                pos  = 6'(data_width - dest_w + b);
                d[b] = flit[pos];
            end
        end
        return d;
    endfunction

    // First requester at or after ptr, searching cyclically over num_ports.
    function automatic rr_pick_t rr_pick(input logic [MAX_PORTS-1:0] req,
                                         input port_idx_t ptr,
                                         input int num_ports);
        rr_pick_t res;
        int       idx;
        res = '0;
        for (int k = 0; k < MAX_PORTS; k++) begin
            idx = (int'(ptr) + k) % num_ports;
            if (k < num_ports && !res.found && req[idx[PORT_W-1:0]]) begin
                res.found  = 1'b1;
                res.winner = port_idx_t'(idx);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/router_fifo.sv
// Input buffer for one router port. Full is registered, so a pop in the same
// cycle never makes room for a push that arrives while full.
module router_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] peek_out
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_next;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        count_next = count;
        if (do_push) count_next = count_next + CNT_ONE;
        if (do_pop)  count_next = count_next - CNT_ONE;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            count <= count_next;
            full  <= (count_next == FULL_COUNT);
            empty <= (count_next == '0);
        end
    end

    // NOTE: storage is not reset; empty/count guard it, and skipping the reset keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= data_in;
    end

    assign peek_out = mem[rd_ptr];

endmodule

// File: rtl/node_router.sv
// N-port mesh router node: per-input FIFO, destination routing from the flit's
// top bits, per-output round-robin arbiter and a registered output stage.
module node_router
    import node_router_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int DEST_W     = $clog2(NUM_PORTS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            in_valid,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
    output logic [NUM_PORTS-1:0]            in_full,
    output logic [NUM_PORTS-1:0]            out_valid,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] out_data,
    input  logic [NUM_PORTS-1:0]            out_full,
    output logic [15:0]                     drop_count
);

    logic [DATA_WIDTH-1:0] head [NUM_PORTS];
    port_idx_t             dest [NUM_PORTS];
    port_idx_t             winner [NUM_PORTS];
    logic [NUM_PORTS-1:0]  fifo_empty;
    logic [NUM_PORTS-1:0]  fifo_pop;
    logic [NUM_PORTS-1:0]  bad_dest;
    logic [NUM_PORTS-1:0]  grant;
    logic [4:0]            drops_now;
    logic [16:0]           drop_sum;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_in
        router_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (DATA_WIDTH)
        ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .push     (in_valid[i]),
            .pop      (fifo_pop[i]),
            .data_in  (in_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .full     (in_full[i]),
            .empty    (fifo_empty[i]),
            .peek_out (head[i])
        );

        assign dest[i]     = dest_of(MAX_FLIT_W'(head[i]), DATA_WIDTH, DEST_W);
        // Destinations past the last port are popped and counted without a grant.
        assign bad_dest[i] = !fifo_empty[i] && (int'(dest[i]) >= NUM_PORTS);
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
        logic [MAX_PORTS-1:0]  req;
        rr_pick_t              pick;
        logic                  load_ok;
        logic [DATA_WIDTH-1:0] sel;
        logic                  valid_q;
        logic [DATA_WIDTH-1:0] data_q;
        port_idx_t             rr_ptr;

        always_comb begin
            req = '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                req[i] = !fifo_empty[i] && (dest[i] == port_idx_t'(o));
            end
        end

        // Loading is allowed into an empty stage or one draining this cycle.
        assign load_ok   = !valid_q || !out_full[o];
        assign pick      = rr_pick(req, rr_ptr, NUM_PORTS);
        assign grant[o]  = pick.found && load_ok;
        assign winner[o] = pick.winner;

        always_comb begin
            sel = '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (pick.winner == port_idx_t'(i)) sel = head[i];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                data_q  <= '0;
                rr_ptr  <= '0;
            end else if (grant[o]) begin
                valid_q <= 1'b1;
                data_q  <= sel;
                rr_ptr  <= (pick.winner == port_idx_t'(NUM_PORTS-1)) ?
                           '0 : pick.winner + port_idx_t'(1);
            end else if (!out_full[o]) begin
                valid_q <= 1'b0;
            end
        end

        assign out_valid[o]                          = valid_q;
        assign out_data[o*DATA_WIDTH +: DATA_WIDTH] = data_q;
    end

    // Each input targets one output, so at most one grant can name it.
    always_comb begin
        fifo_pop = bad_dest;
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (grant[o] && winner[o] == port_idx_t'(i)) fifo_pop[i] = 1'b1;
            end
        end
    end

    always_comb begin
        drops_now = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            drops_now = drops_now + 5'(in_valid[i] && in_full[i]) + 5'(bad_dest[i]);
        end
        drop_sum = {1'b0, drop_count} + {12'b0, drops_now};
    end

    always_ff @(posedge clk) begin
        if (rst)              drop_count <= '0;
        else if (drop_sum[16]) drop_count <= 16'hFFFF;
        else                   drop_count <= drop_sum[15:0];
    end

endmodule
